// File: rtl/vga_pixel_pipe.sv
// ---------------------------------------------------------------------------
// vga_pixel_pipe : 2-stage RGB222 pixel pipe drawing a bouncing box on a checkerboard
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module vga_pixel_pipe #(
  parameter int   H_ACTIVE  = 640,
  parameter int   V_ACTIVE  = 480,
  parameter int   BOX_SIZE  = 32,
  parameter int   STEP      = 1,
  parameter int   CHECK_BIT = 5,
  parameter logic SYNC_IDLE = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clk_en,
  input  logic       active,
  input  logic       hsync,
  input  logic       vsync,
  input  logic       v_begin,
  input  logic [9:0] hpos,
  input  logic [9:0] vpos,
  input  logic       pause,
  output logic [1:0] r,
  output logic [1:0] g,
  output logic [1:0] b,
  output logic       hsync_o,
  output logic       vsync_o
);

  localparam logic [10:0] H_LIM  = 11'(H_ACTIVE);
  localparam logic [10:0] V_LIM  = 11'(V_ACTIVE);
  localparam logic [10:0] BOX11  = 11'(BOX_SIZE);
  localparam logic [10:0] STEP11 = 11'(STEP);
  localparam logic [9:0]  STEP10 = 10'(STEP);
  localparam logic [9:0]  BX_MAX = 10'(H_ACTIVE - BOX_SIZE);
  localparam logic [9:0]  BY_MAX = 10'(V_ACTIVE - BOX_SIZE);

  logic [9:0]  bx, by, bx_nxt, by_nxt;
  logic        dx, dy, dx_nxt, dy_nxt;
  logic [10:0] bx_end, by_end;
  logic        in_box, chk;

  logic        s1_active, s1_in_box, s1_chk, s1_hsync, s1_vsync;

  // 11-bit comparisons so bx+BOX_SIZE can never wrap
  assign bx_end = {1'b0, bx} + BOX11;
  assign by_end = {1'b0, by} + BOX11;
  assign in_box = ({1'b0, hpos} >= {1'b0, bx}) && ({1'b0, hpos} < bx_end) &&
                  ({1'b0, vpos} >= {1'b0, by}) && ({1'b0, vpos} < by_end);
  assign chk    = hpos[CHECK_BIT] ^ vpos[CHECK_BIT];

  // Next box position: clamp to the edge and reverse rather than overshoot
  always_comb begin
    bx_nxt = bx;
    dx_nxt = dx;
    by_nxt = by;
    dy_nxt = dy;
    if (dx) begin
      if ({1'b0, bx} + STEP11 + BOX11 > H_LIM) begin
        bx_nxt = BX_MAX;
        dx_nxt = 1'b0;
      end else begin
        bx_nxt = bx + STEP10;
      end
    end else if (bx < STEP10) begin
      bx_nxt = '0;
      dx_nxt = 1'b1;
    end else begin
      bx_nxt = bx - STEP10;
    end
    if (dy) begin
      if ({1'b0, by} + STEP11 + BOX11 > V_LIM) begin
        by_nxt = BY_MAX;
        dy_nxt = 1'b0;
      end else begin
        by_nxt = by + STEP10;
      end
    end else if (by < STEP10) begin
      by_nxt = '0;
      dy_nxt = 1'b1;
    end else begin
      by_nxt = by - STEP10;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bx        <= '0;
      by        <= '0;
      dx        <= 1'b1;
      dy        <= 1'b1;
      s1_active <= 1'b0;
      s1_in_box <= 1'b0;
      s1_chk    <= 1'b0;
      s1_hsync  <= SYNC_IDLE;
      s1_vsync  <= SYNC_IDLE;
      r         <= '0;
      g         <= '0;
      b         <= '0;
      hsync_o   <= SYNC_IDLE;
      vsync_o   <= SYNC_IDLE;
    end else if (clk_en) begin
      s1_active <= active;
      s1_in_box <= in_box;
      s1_chk    <= chk;
      s1_hsync  <= hsync;
      s1_vsync  <= vsync;

      if (!s1_active)     {r, g, b} <= 6'b000000;
      else if (s1_in_box) {r, g, b} <= 6'b111111;
      else if (s1_chk)    {r, g, b} <= 6'b000001;
      else                {r, g, b} <= 6'b000000;
      hsync_o <= s1_hsync;
      vsync_o <= s1_vsync;

      // The pixel sampled alongside v_begin still sees the old position
      if (v_begin && !pause) begin
        bx <= bx_nxt;
        dx <= dx_nxt;
        by <= by_nxt;
        dy <= dy_nxt;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vga_pixel_pipe.sv
// ---------------------------------------------------------------------------
// tb_vga_pixel_pipe : self-checking bench for vga_pixel_pipe (small mode)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_vga_pixel_pipe;

  localparam int   H  = 8;
  localparam int   V  = 6;
  localparam int   BS = 2;
  localparam int   ST = 1;
  localparam int   CB = 1;
  localparam logic SI = 1'b1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clk_en = 1'b0, active = 1'b0, hsync = 1'b0, vsync = 1'b0;
  logic       v_begin = 1'b0, pause = 1'b0;
  logic [9:0] hpos = '0, vpos = '0;
  logic [1:0] r, g, b;
  logic       hsync_o, vsync_o;
  logic [7:0] obs;

  vga_pixel_pipe #(
    .H_ACTIVE (H), .V_ACTIVE (V), .BOX_SIZE (BS), .STEP (ST),
    .CHECK_BIT (CB), .SYNC_IDLE (SI)
  ) dut (
    .clk (clk), .rst_n (rst_n), .clk_en (clk_en), .active (active),
    .hsync (hsync), .vsync (vsync), .v_begin (v_begin),
    .hpos (hpos), .vpos (vpos), .pause (pause),
    .r (r), .g (g), .b (b), .hsync_o (hsync_o), .vsync_o (vsync_o)
  );

  always #5 clk = ~clk;
  assign obs = {r, g, b, hsync_o, vsync_o};

  int checks = 0;
  int failures = 0;

  // Reference model: box as integers, outputs as a two-entry delay line
  int mbx, mby, mdx, mdy;
  logic [7:0] exp1, exp2;

  function automatic logic [5:0] colour(int hp, int vp, logic act);
    if (!act) return 6'b000000;
    if (hp >= mbx && hp < mbx + BS && vp >= mby && vp < mby + BS) return 6'b111111;
    if ((((hp >> CB) ^ (vp >> CB)) & 1) == 1) return 6'b000001;
    return 6'b000000;
  endfunction

  task automatic check(input string tag, input logic [7:0] o, input logic [7:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, o, e);
    end
  endtask

  task automatic model_reset();
    mbx = 0; mby = 0; mdx = 1; mdy = 1;
    exp1 = {6'b000000, SI, SI};
    exp2 = exp1;
  endtask

  task automatic move();
    if (mdx == 1) begin
      if (mbx + ST + BS > H) begin mbx = H - BS; mdx = 0; end
      else mbx = mbx + ST;
    end else begin
      if (mbx < ST) begin mbx = 0; mdx = 1; end
      else mbx = mbx - ST;
    end
    if (mdy == 1) begin
      if (mby + ST + BS > V) begin mby = V - BS; mdy = 0; end
      else mby = mby + ST;
    end else begin
      if (mby < ST) begin mby = 0; mdy = 1; end
      else mby = mby - ST;
    end
  endtask

  // One clock: drive, advance the model on enabled edges, compare after the edge
  task automatic cyc(input logic en, input logic act, input logic hs, input logic vs,
                     input logic vb, input logic pa, input int hp, input int vp,
                     input string tag);
    clk_en = en; active = act; hsync = hs; vsync = vs;
    v_begin = vb; pause = pa; hpos = 10'(hp); vpos = 10'(vp);
    @(posedge clk);
    #1;
    if (en) begin
      exp2 = exp1;
      exp1 = {colour(hp, vp, act), hs, vs};
      if (vb && !pa) move();
    end
    check(tag, obs, exp2);
  endtask

  task automatic scan(input string tag);
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++)
        cyc(1'b1, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'b0, 1'b0, x, y, tag);
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, tag);
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, tag);
  endtask

  // Asserts reset between edges and checks the outputs before any clock edge
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    model_reset();
    check(tag, obs, exp2);
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    #6;
    do_reset("reset_state");

    // Idle syncs flush out, then the driven sync pattern follows two edges later
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, "post_reset_e1");
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, "post_reset_e2");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, "sync_delay_e3");
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, "sync_delay_e4");

    // Frame 0 directed pixels: box corner, checker cells and background
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, "f0_px00");
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1, 0, "f0_px10");
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1, "f0_px01");
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1, 1, "f0_px11");
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2, 0, "f0_px20");
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 2, "f0_px02");
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3, 3, "f0_px33");
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, "f0_flush1");
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, "f0_flush2");

    // Consecutive frames through the right/bottom bounce
    for (int f = 0; f < 8; f++) begin
      cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1, 1, "vbegin_old_pos");
      scan("motion_scan");
    end

    // Paused frames leave the box where it is
    for (int f = 0; f < 3; f++) begin
      cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 0, 0, "pause_vbegin");
      scan("pause_scan");
    end
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0, "resume_vbegin");
    scan("resume_scan");

    // Enable gating during a line, including a v_begin under clk_en=0
    for (int i = 0; i < 8; i++)
      cyc(1'((i % 2) == 0), 1'b1, 1'(i % 2), 1'((i / 2) % 2), 1'b0, 1'b0, i, 2, "clk_en_toggle");
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3, 3, "vbegin_gated");
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4, 3, "vbegin_gated");
    scan("gated_scan");

    // Randomised traffic across many bounces
    for (int i = 0; i < 3000; i++)
      cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) != 0),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 3) == 0),
          int'($urandom_range(0, H - 1)), int'($urandom_range(0, V - 1)), "random");

    // Mid-line reset while a box pixel is on the outputs
    do_reset("reset2");
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 9, 9, "move_away");
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1, "move_away_px");
    end
    scan("pre_midreset_scan");
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, mbx, mby, "box_px_in");
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, mbx, mby, "box_px_in2");
    check("box_px_white", {obs[7:2], 2'b00}, 8'b11111100);
    do_reset("midline_reset_async");
    scan("restart_scan");
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0, "restart_vbegin");
    scan("restart_dir_scan");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
